// File: rtl/da_sample_spi_streamer_if.sv
// Avalon-MM register bus of da_sample_spi_streamer.
// The host drives the master side and the streamer is the slave.
interface da_sample_spi_streamer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/da_sample_spi_streamer.sv
// DAC sample streamer: buffers samples written over Avalon-MM in a FIFO and, on each rising
// edge of the timer tick, pops one sample and shifts it out MSB-first as a single SPI frame.
module da_sample_spi_streamer #(
    parameter int FIFO_DEPTH = 16,
    parameter int DAC_BITS   = 16,
    parameter int CLK_DIV    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    da_sample_spi_streamer_if.slave   bus,
    input  logic                      tick,
    output logic                      irq,
    output logic                      dac_sclk,
    output logic                      dac_cs_n,
    output logic                      dac_mosi
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int HCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW  = $clog2(2 * DAC_BITS);
    localparam logic [HCW-1:0] HC_LAST  = HCW'(CLK_DIV - 1);
    localparam logic [TW-1:0]  TG_LAST  = TW'(2 * DAC_BITS - 1);
    localparam logic [LW-1:0]  LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [HCW-1:0]        hc_q, hc_d;
    logic [TW-1:0]         tg_q, tg_d;
    logic [DAC_BITS-1:0]   sh_q, sh_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  mosi_q, mosi_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic [LW-1:0]         thr_q, thr_d;
    logic                  underrun_q, underrun_d;
    logic                  overflow_q, overflow_d;
    logic                  miss_q, miss_d;
    logic                  tick_prev_q;
    logic [15:0]           rdata_q, rdata_d;
    logic [DAC_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                  wr_en, req, empty, full, busy;
    logic                  push_try, push, pop, flush;
    logic [DAC_BITS-1:0]   pop_data;
    logic                  unused_bits;

    assign wr_en    = bus.chipselect & ~bus.write_n;
    assign req      = tick & ~tick_prev_q & ctrl_q[0];
    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_FULL);
    assign busy     = (state_q != S_IDLE);
    assign push_try = wr_en & (bus.address == 2'd0);
    assign flush    = wr_en & (bus.address == 2'd1) & bus.writedata[2];
    assign push     = push_try & ~full & ~flush;
    assign pop      = ~busy & req & ~empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign unused_bits = ^bus.writedata;

    always_comb begin
        state_d    = state_q;
        hc_d       = hc_q;
        tg_d       = tg_q;
        sh_d       = sh_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ctrl_d     = ctrl_q;
        thr_d      = thr_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        miss_d     = miss_q;
        rdata_d    = '0;

        if (wr_en) begin
            case (bus.address)
                2'd1:    ctrl_d = bus.writedata[1:0];
                2'd2: begin
                    underrun_d = 1'b0;
                    overflow_d = 1'b0;
                    miss_d     = 1'b0;
                end
                2'd3:    thr_d = bus.writedata[LW-1:0];
                default: ;
            endcase
        end

        // Event sets come after the write-clear so they win in the same cycle
        if (req && busy)            miss_d     = 1'b1;
        if (req && !busy && empty)  underrun_d = 1'b1;
        if (push_try && full)       overflow_d = 1'b1;

        if (flush) begin
            level_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(push) - LW'(pop);
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_SETUP;
                    hc_d    = '0;
                    tg_d    = '0;
                    sh_d    = pop_data;
                    sclk_d  = 1'b0;
                    cs_n_d  = 1'b0;
                    mosi_d  = pop_data[DAC_BITS-1];
                end
            end
            S_SETUP: begin
                if (hc_q == HC_LAST) begin
                    hc_d    = '0;
                    state_d = S_SHIFT;
                end else begin
                    hc_d = hc_q + HCW'(1);
                end
            end
            S_SHIFT: begin
                if (hc_q == HC_LAST) begin
                    hc_d   = '0;
                    sclk_d = ~sclk_q;
                    if (tg_q == TG_LAST) begin
                        state_d = S_HOLD;
                        cs_n_d  = 1'b1;
                    end else begin
                        tg_d = tg_q + TW'(1);
                        // Data advances only on falling SCLK so it is stable at the rising edge
                        if (sclk_q) begin
                            sh_d   = sh_q << 1;
                            mosi_d = sh_d[DAC_BITS-1];
                        end
                    end
                end else begin
                    hc_d = hc_q + HCW'(1);
                end
            end
            S_HOLD: begin
                if (hc_q == HC_LAST) begin
                    hc_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    hc_d = hc_q + HCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (bus.address)
            2'd0:    rdata_d = 16'(level_q);
            2'd1:    rdata_d = 16'(ctrl_q);
            2'd2:    rdata_d = {10'd0, full, empty, miss_q, overflow_q, underrun_q, busy};
            default: rdata_d = 16'(thr_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            hc_q        <= '0;
            tg_q        <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ctrl_q      <= '0;
            thr_q       <= '0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
            miss_q      <= 1'b0;
            tick_prev_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            hc_q        <= hc_d;
            tg_q        <= tg_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ctrl_q      <= ctrl_d;
            thr_q       <= thr_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
            miss_q      <= miss_d;
            tick_prev_q <= tick;
            rdata_q     <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q <= sh_d;
        if (push) mem_q[wr_ptr_q] <= bus.writedata[DAC_BITS-1:0];
    end

    assign dac_sclk     = sclk_q;
    assign dac_cs_n     = cs_n_q;
    assign dac_mosi     = mosi_q;
    assign bus.readdata = rdata_q;
    assign irq          = ctrl_q[1] & (level_q <= thr_q);
endmodule

// File: tb/tb_da_sample_spi_streamer.sv
// Bench for da_sample_spi_streamer: directed sequence with random samples, checked against
// a queue-based model of the FIFO, sticky status bits and the expected SPI frame shape.
module tb_da_sample_spi_streamer;
    localparam int DEPTH = 16;
    localparam int BITS  = 16;
    localparam int DIV   = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic tick;
    logic irq, dac_sclk, dac_cs_n, dac_mosi;

    always #5 clk = ~clk;

    da_sample_spi_streamer_if bus();

    da_sample_spi_streamer #(.FIFO_DEPTH(DEPTH), .DAC_BITS(BITS), .CLK_DIV(DIV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .tick     (tick),
        .irq      (irq),
        .dac_sclk (dac_sclk),
        .dac_cs_n (dac_cs_n),
        .dac_mosi (dac_mosi)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] fq[$];
    bit m_en, m_irqen, m_under, m_over, m_miss;
    int m_thr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        return {26'd0, fq.size() == DEPTH, fq.size() == 0, m_miss, m_over, m_under, 1'b0};
    endfunction

    function automatic logic [31:0] irq_exp();
        return {31'd0, m_irqen && (fq.size() <= m_thr)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        cyc();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        bus.address = a;
        cyc();
        d = bus.readdata;
    endtask

    task automatic push(input logic [15:0] d);
        wr(2'd0, d);
        if (fq.size() < DEPTH) fq.push_back(d);
        else m_over = 1'b1;
    endtask

    task automatic set_ctrl(input logic [15:0] v);
        wr(2'd1, v);
        m_en    = v[0];
        m_irqen = v[1];
        if (v[2]) fq.delete();
    endtask

    task automatic clear_status();
        wr(2'd2, 16'h0);
        m_under = 1'b0;
        m_over  = 1'b0;
        m_miss  = 1'b0;
    endtask

    task automatic model_reset();
        fq.delete();
        m_en = 0; m_irqen = 0; m_under = 0; m_over = 0; m_miss = 0; m_thr = 0;
    endtask

    // Raise tick, optionally a second time at cycle second_at, and observe 90 cycles of SPI
    task automatic do_frame(input string tag, input int second_at);
        int cs_low = 0;
        int rises = 0;
        logic prev = 1'b0;
        logic [15:0] bits = '0;
        logic [15:0] exp_s = '0;
        bit expect_frame;
        expect_frame = m_en && (fq.size() > 0);
        if (m_en) begin
            if (expect_frame) exp_s = fq.pop_front();
            else m_under = 1'b1;
        end
        if (second_at > 0 && expect_frame) m_miss = 1'b1;
        tick = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            cyc();
            if (c == 3) tick = 1'b0;
            if (second_at > 0 && c == second_at) tick = 1'b1;
            if (second_at > 0 && c == second_at + 3) tick = 1'b0;
            if (!dac_cs_n) cs_low++;
            if (dac_sclk && !prev) begin
                rises++;
                bits = {bits[14:0], dac_mosi};
            end
            prev = dac_sclk;
        end
        chk({tag, "_cs_low"}, cs_low, expect_frame ? (2 * BITS + 1) * DIV : 0);
        chk({tag, "_rises"}, rises, expect_frame ? BITS : 0);
        chk({tag, "_bits"}, {16'd0, bits}, {16'd0, exp_s});
    endtask

    initial begin
        logic [15:0] r;
        reset_n        = 1'b0;
        tick           = 1'b0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        model_reset();
        repeat (3) cyc();
        chk("rst_cs_n", {31'd0, dac_cs_n}, 32'd1);
        chk("rst_sclk", {31'd0, dac_sclk}, 32'd0);
        chk("rst_mosi", {31'd0, dac_mosi}, 32'd0);
        chk("rst_rdata", {16'd0, bus.readdata}, 32'd0);
        chk("rst_irq", {31'd0, irq}, irq_exp());
        reset_n = 1'b1;
        cyc();
        rd(2'd2, r);
        chk("rst_status", {16'd0, r}, status_exp());

        // Single directed frame, then random samples
        push(16'hA5C3);
        rd(2'd0, r);
        chk("t1_level1", {16'd0, r}, fq.size());
        set_ctrl(16'h1);
        do_frame("t1_a5c3", 0);
        rd(2'd0, r);
        chk("t1_level0", {16'd0, r}, fq.size());
        for (int i = 0; i < 3; i++) begin
            push(16'($urandom));
            do_frame("t1_rand", 0);
        end

        // Underrun with empty FIFO
        do_frame("t3_empty", 0);
        rd(2'd2, r);
        chk("t3_status", {16'd0, r}, status_exp());
        clear_status();
        rd(2'd2, r);
        chk("t3_cleared", {16'd0, r}, status_exp());

        // Overflow past depth
        for (int i = 0; i < DEPTH + 1; i++) push(16'($urandom));
        rd(2'd0, r);
        chk("t2_level", {16'd0, r}, fq.size());
        rd(2'd2, r);
        chk("t2_status", {16'd0, r}, status_exp());
        clear_status();
        rd(2'd2, r);
        chk("t2_cleared", {16'd0, r}, status_exp());
        do_frame("t2_order", 0);
        rd(2'd0, r);
        chk("t2_level_pop", {16'd0, r}, fq.size());
        set_ctrl(16'h5);
        rd(2'd0, r);
        chk("t2_flush", {16'd0, r}, fq.size());

        // Tick while busy
        push(16'($urandom));
        push(16'($urandom));
        do_frame("t4_frame", 10);
        rd(2'd0, r);
        chk("t4_level", {16'd0, r}, fq.size());
        rd(2'd2, r);
        chk("t4_status", {16'd0, r}, status_exp());
        clear_status();

        // Low-watermark interrupt
        set_ctrl(16'h7);
        wr(2'd3, 16'd2);
        m_thr = 2;
        rd(2'd3, r);
        chk("t5_thr", {16'd0, r}, m_thr);
        for (int i = 0; i < 4; i++) push(16'($urandom));
        chk("t5_irq_4", {31'd0, irq}, irq_exp());
        do_frame("t5_f1", 0);
        chk("t5_irq_3", {31'd0, irq}, irq_exp());
        do_frame("t5_f2", 0);
        chk("t5_irq_2", {31'd0, irq}, irq_exp());
        set_ctrl(16'h1);
        chk("t5_irq_off", {31'd0, irq}, irq_exp());

        // Reset in the middle of a frame
        push(16'($urandom));
        tick = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (c == 3) tick = 1'b0;
        end
        chk("t6_midframe_cs", {31'd0, dac_cs_n}, 32'd0);
        reset_n = 1'b0;
        cyc();
        model_reset();
        chk("t6_cs_n", {31'd0, dac_cs_n}, 32'd1);
        chk("t6_sclk", {31'd0, dac_sclk}, 32'd0);
        chk("t6_rdata", {16'd0, bus.readdata}, 32'd0);
        reset_n = 1'b1;
        rd(2'd0, r);
        chk("t6_level", {16'd0, r}, fq.size());
        rd(2'd1, r);
        chk("t6_ctrl", {16'd0, r}, 32'd0);
        rd(2'd2, r);
        chk("t6_status", {16'd0, r}, status_exp());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
